// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 device-to-host frame receiver with clock glitch filter
module ps2_rx_frame #(
    parameter int FILT_LEN = 4,
    parameter int TIMEOUT  = 5000,
    parameter int TO_W     = 13
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       M_CLK,
    input  logic       M_Dat,
    input  logic       En,
    output logic [7:0] Dato,
    output logic       Dato_valido,
    output logic       Error_paridad,
    output logic       Error_trama,
    output logic       Ocupado
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);

    logic                clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FILT_LEN-1:0] filt_sr;
    logic                filt_clk, filt_prev;
    logic                fall;

    state_t              state, state_n;
    logic [3:0]          bit_cnt, bit_cnt_n;
    logic [TO_W-1:0]     to_cnt, to_cnt_n;
    logic [9:0]          shreg, shreg_n;
    logic [7:0]          dato_n;
    logic                valid_n, perr_n, ferr_n;

    assign fall = filt_prev & ~filt_clk;

    // Front end: sync flops, tap filter and edge history all idle high like the bus
    always_ff @(posedge Clk) begin
        if (Rst) begin
            clk_s1    <= 1'b1;
            clk_s2    <= 1'b1;
            dat_s1    <= 1'b1;
            dat_s2    <= 1'b1;
            filt_sr   <= '1;
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
        end else begin
            clk_s1    <= M_CLK;
            clk_s2    <= clk_s1;
            dat_s1    <= M_Dat;
            dat_s2    <= dat_s1;
            filt_sr   <= {filt_sr[FILT_LEN-2:0], clk_s2};
            filt_prev <= filt_clk;
            if (filt_sr == '0) begin
                filt_clk <= 1'b0;
            end else if (&filt_sr) begin
                filt_clk <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        to_cnt_n  = '0;
        shreg_n   = shreg;
        dato_n    = Dato;
        valid_n   = 1'b0;
        perr_n    = 1'b0;
        ferr_n    = 1'b0;
        if (!En) begin
            state_n   = IDLE;
            bit_cnt_n = 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (fall && !dat_s2) begin
                        state_n   = RECV;
                        bit_cnt_n = 4'd0;
                    end
                end
                RECV: begin
                    // A fall always beats a timeout landing in the same cycle
                    if (fall) begin
                        shreg_n   = {dat_s2, shreg[9:1]};
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd9) begin
                            state_n = DONE;
                            if (!dat_s2) begin
                                ferr_n = 1'b1;
                            end else if (^shreg_n[8:0] == 1'b0) begin
                                perr_n = 1'b1;
                            end else begin
                                valid_n = 1'b1;
                                dato_n  = shreg_n[7:0];
                            end
                        end
                    end else if (to_cnt == TO_MAX) begin
                        state_n = IDLE;
                        ferr_n  = 1'b1;
                    end else begin
                        to_cnt_n = to_cnt + 1'b1;
                    end
                end
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Strobes are registered on the deciding edge so they appear in the DONE cycle
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state         <= IDLE;
            bit_cnt       <= 4'd0;
            to_cnt        <= '0;
            shreg         <= '0;
            Dato          <= 8'h00;
            Dato_valido   <= 1'b0;
            Error_paridad <= 1'b0;
            Error_trama   <= 1'b0;
            Ocupado       <= 1'b0;
        end else begin
            state         <= state_n;
            bit_cnt       <= bit_cnt_n;
            to_cnt        <= to_cnt_n;
            shreg         <= shreg_n;
            Dato          <= dato_n;
            Dato_valido   <= valid_n;
            Error_paridad <= perr_n;
            Error_trama   <= ferr_n;
            Ocupado       <= (state_n == RECV);
        end
    end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb/tb_ps2_rx_frame.sv - randomized and directed frame checks for ps2_rx_frame
module tb_ps2_rx_frame;

    localparam int FILT_LEN = 4;
    localparam int TIMEOUT  = 5000;
    localparam int TO_W     = 13;

    logic       Clk = 1'b0;
    logic       Rst, M_CLK, M_Dat, En;
    logic [7:0] Dato;
    logic       Dato_valido, Error_paridad, Error_trama, Ocupado;

    int n_assert = 0;
    int n_fail   = 0;
    int v_cnt = 0, p_cnt = 0, f_cnt = 0, multi_cnt = 0;
    int v0, p0, f0;
    logic [7:0] exp_dato = 8'h00;

    ps2_rx_frame #(.FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .Clk(Clk), .Rst(Rst), .M_CLK(M_CLK), .M_Dat(M_Dat), .En(En),
        .Dato(Dato), .Dato_valido(Dato_valido), .Error_paridad(Error_paridad),
        .Error_trama(Error_trama), .Ocupado(Ocupado)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Dato_valido) v_cnt++;
        if (Error_paridad) p_cnt++;
        if (Error_trama) f_cnt++;
        if (int'(Dato_valido) + int'(Error_paridad) + int'(Error_trama) > 1) multi_cnt++;
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic snap();
        v0 = v_cnt; p0 = p_cnt; f0 = f_cnt;
    endtask

    task automatic chk_deltas(input string tag, input int ev, input int ep, input int ef);
        chk({tag, " valid"}, v_cnt - v0, ev);
        chk({tag, " perr"}, p_cnt - p0, ep);
        chk({tag, " ferr"}, f_cnt - f0, ef);
    endtask

    // One PS/2 bit cell: 40 cycles high (data set early), 40 cycles low
    task automatic send_bit(input logic b, input logic glitch);
        M_Dat = b;
        tick(5);
        if (glitch) begin
            M_CLK = 1'b0;
            tick(2);
            M_CLK = 1'b1;
            tick(13);
        end else begin
            tick(15);
        end
        M_CLK = 1'b0;
        tick(40);
        M_CLK = 1'b1;
        tick(20);
    endtask

    task automatic send_bits(input logic [10:0] fr, input int lo, input int hi, input int glitch_at);
        for (int i = lo; i <= hi; i++) send_bit(fr[i], i == glitch_at);
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic par, input logic stp);
        return {stp, par, d, 1'b0};
    endfunction

    // 0 = good byte, 1 = parity error, 2 = framing error
    function automatic int model_kind(input logic [7:0] d, input logic par, input logic stp);
        if (!stp) return 2;
        if (($countones({d, par}) % 2) == 0) return 1;
        return 0;
    endfunction

    task automatic run_frame(input string tag, input logic [7:0] d, input logic par,
                             input logic stp, input int glitch_at);
        logic [10:0] fr;
        int k;
        fr = mk(d, par, stp);
        snap();
        send_bits(fr, 0, 5, glitch_at);
        chk({tag, " busy"}, int'(Ocupado), 1);
        send_bits(fr, 6, 10, glitch_at);
        tick(4);
        k = model_kind(d, par, stp);
        if (k == 0) exp_dato = d;
        chk_deltas(tag, int'(k == 0), int'(k == 1), int'(k == 2));
        chk({tag, " dato"}, int'(Dato), int'(exp_dato));
        chk({tag, " idle"}, int'(Ocupado), 0);
    endtask

    initial begin
        logic [10:0] fr;
        logic [7:0]  rd;
        logic        rp, rs;

        Rst = 1'b1; En = 1'b1; M_CLK = 1'b1; M_Dat = 1'b1;
        tick(5);
        chk("rst dato", int'(Dato), 0);
        chk("rst valid", int'(Dato_valido), 0);
        chk("rst perr", int'(Error_paridad), 0);
        chk("rst ferr", int'(Error_trama), 0);
        chk("rst busy", int'(Ocupado), 0);
        Rst = 1'b0;
        tick(10);

        run_frame("a5_good", 8'hA5, 1'b1, 1'b1, -1);
        run_frame("a5_badpar", 8'hA5, 1'b0, 1'b1, -1);
        run_frame("3c_stop0", 8'h3C, 1'b0, 1'b0, -1);

        snap();
        send_bits(mk(8'h00, 1'b1, 1'b1), 0, 4, -1);
        chk("to busy", int'(Ocupado), 1);
        tick(TIMEOUT + 10);
        chk_deltas("timeout", 0, 0, 1);
        chk("to idle", int'(Ocupado), 0);
        run_frame("08_after_to", 8'h08, 1'b0, 1'b1, -1);

        snap();
        M_Dat = 1'b0;
        tick(5);
        M_CLK = 1'b0;
        tick(2);
        M_CLK = 1'b1;
        tick(20);
        chk("idle glitch busy", int'(Ocupado), 0);
        M_Dat = 1'b1;
        tick(20);
        chk_deltas("idle glitch", 0, 0, 0);
        run_frame("5a_glitch", 8'h5A, 1'b1, 1'b1, 3);

        fr = mk(8'hC3, 1'b1, 1'b1);
        snap();
        send_bits(fr, 0, 6, -1);
        Rst = 1'b1;
        tick(1);
        Rst = 1'b0;
        exp_dato = 8'h00;
        chk("midrst dato", int'(Dato), 0);
        chk("midrst busy", int'(Ocupado), 0);
        send_bits(fr, 7, 10, -1);
        tick(4);
        chk_deltas("midrst tail", 0, 0, 0);
        chk("midrst idle", int'(Ocupado), 0);
        run_frame("ff_after_rst", 8'hFF, 1'b1, 1'b1, -1);

        fr = mk(8'hF0, 1'b1, 1'b1);
        snap();
        send_bits(fr, 0, 4, -1);
        En = 1'b0;
        tick(2);
        chk("en_low busy", int'(Ocupado), 0);
        En = 1'b1;
        send_bits(fr, 5, 10, -1);
        tick(4);
        chk_deltas("en_low", 0, 0, 0);
        chk("en_low dato", int'(Dato), int'(exp_dato));

        for (int i = 0; i < 8; i++) begin
            rd = 8'($urandom);
            rp = 1'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            run_frame($sformatf("rand%0d", i), rd, rp, rs, -1);
        end

        chk("single strobe", multi_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
